// File: rtl/ma_pkg.sv
// Shared types and default widths for the ma command queue and its FIFO.
package ma_pkg;

    localparam int DEF_DEPTH          = 4;
    localparam int DEF_VRF_ADDRWIDTH  = 10;
    localparam int DEF_MRF_ADDRWIDTH  = 6;
    localparam int DEF_ARF_ADDRWIDTH  = 5;
    localparam int DEF_ARF_DATAWIDTH  = 36;
    localparam int DEF_TIMEOUT_CYCLES = 1024;

    typedef struct packed {
        logic                         sel_v_m;
        logic                         load_or_store;
        logic [DEF_VRF_ADDRWIDTH-1:0] v_m_reg;
        logic [DEF_ARF_ADDRWIDTH-1:0] a_reg;
        logic [DEF_ARF_DATAWIDTH-1:0] a_offset;
    } ma_cmd_t;

    localparam int CMD_W = $bits(ma_cmd_t);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2
    } ma_cmd_state_e;

endpackage

// File: rtl/ma_cmd_fifo.sv
// Synchronous FIFO of packed ma_cmd_t words; DEPTH must be a power of two.
module ma_cmd_fifo
    import ma_pkg::*;
#(
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       i_push,
    input  logic                       i_pop,
    input  logic [CMD_W-1:0]           i_wdata,
    output logic [CMD_W-1:0]           o_rdata,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_full,
    output logic                       o_empty
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [CMD_W-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;

    assign o_rdata = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);

    // Storage needs no reset; occupancy is tracked by the pointers and count.
    always_ff @(posedge clk) begin
        if (i_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (i_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            if (i_push && !i_pop)      r_count <= r_count + CW'(1);
            else if (i_pop && !i_push) r_count <= r_count - CW'(1);
        end
    end

endmodule

// File: rtl/ma_cmd_queue.sv
// Buffers ma load/store commands and issues them one at a time, gated by DDR4 link-up.
// Optional watchdog on the WAIT state enabled by defining MA_CMD_QUEUE_TIMEOUT_EN.
module ma_cmd_queue
  import ma_pkg::*;
#(
  parameter int DEPTH          = DEF_DEPTH,
  parameter int VRF_ADDRWIDTH  = DEF_VRF_ADDRWIDTH,
  parameter int MRF_ADDRWIDTH  = DEF_MRF_ADDRWIDTH,
  parameter int ARF_ADDRWIDTH  = DEF_ARF_ADDRWIDTH,
  parameter int ARF_DATAWIDTH  = DEF_ARF_DATAWIDTH,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cmd_valid_i,
  output logic                       cmd_ready_o,
  input  logic                       cmd_sel_v_m_i,
  input  logic                       cmd_load_or_store_i,
  input  logic [VRF_ADDRWIDTH-1:0]   cmd_v_m_reg_i,
  input  logic [ARF_ADDRWIDTH-1:0]   cmd_a_reg_i,
  input  logic [ARF_DATAWIDTH-1:0]   cmd_a_offset_i,
  input  logic                       ddr4_linkup_i,
  output logic                       ma_start_o,
  output logic                       ma_select_v_m_o,
  output logic                       ma_v_load_or_store_o,
  output logic [VRF_ADDRWIDTH-1:0]   ma_v_m_reg_o,
  output logic [ARF_ADDRWIDTH-1:0]   ma_a_reg_o,
  output logic [ARF_DATAWIDTH-1:0]   ma_a_offset_o,
  input  logic                       ma_done_i,
  output logic                       busy_o,
  output logic [$clog2(DEPTH+1)-1:0] q_count_o,
  output logic [15:0]                retired_o,
  output logic [1:0]                 dbg_state_o
`ifdef MA_CMD_QUEUE_TIMEOUT_EN
  ,
  output logic                       timeout_o
`endif
);

  // Valid/ready: a command transfers on every rising edge where cmd_valid_i
  // and cmd_ready_o are both high; ready depends only on registered occupancy.

  localparam logic [VRF_ADDRWIDTH-1:0] M_MASK = VRF_ADDRWIDTH'((1 << MRF_ADDRWIDTH) - 1);

  ma_cmd_state_e r_state;
  ma_cmd_state_e w_state_next;
  ma_cmd_t       w_cmd_in;
  ma_cmd_t       w_cmd_head;
  logic          w_push;
  logic          w_pop;
  logic          w_retire;
  logic          w_full;
  logic          w_empty;

  logic                     r_start;
  logic                     r_sel;
  logic                     r_ls;
  logic [VRF_ADDRWIDTH-1:0] r_vm_reg;
  logic [ARF_ADDRWIDTH-1:0] r_a_reg;
  logic [ARF_DATAWIDTH-1:0] r_a_off;
  logic [15:0]              r_retired;

`ifdef MA_CMD_QUEUE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES+1);
  logic [TW-1:0] r_wait_cnt;
  logic          r_timeout;
  logic          w_timeout;
`endif

  always_comb begin
    w_cmd_in               = '0;
    w_cmd_in.sel_v_m       = cmd_sel_v_m_i;
    w_cmd_in.load_or_store = cmd_load_or_store_i;
    w_cmd_in.v_m_reg       = cmd_v_m_reg_i;
    w_cmd_in.a_reg         = cmd_a_reg_i;
    w_cmd_in.a_offset      = cmd_a_offset_i;
  end

  assign cmd_ready_o = !w_full;
  assign w_push      = cmd_valid_i && cmd_ready_o;

  ma_cmd_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (w_cmd_in),
    .o_rdata (w_cmd_head),
    .o_count (q_count_o),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    w_retire     = 1'b0;
`ifdef MA_CMD_QUEUE_TIMEOUT_EN
    w_timeout    = 1'b0;
`endif
    case (r_state)
      ST_IDLE: begin
        if (!w_empty && ddr4_linkup_i) begin
          w_pop        = 1'b1;
          w_state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: w_state_next = ST_WAIT;
      ST_WAIT: begin
        // Done has priority over a watchdog expiry on the same edge.
        if (ma_done_i) begin
          w_retire     = 1'b1;
          w_state_next = ST_IDLE;
        end
`ifdef MA_CMD_QUEUE_TIMEOUT_EN
        else if (r_wait_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
          w_timeout    = 1'b1;
          w_state_next = ST_IDLE;
        end
`endif
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_start   <= 1'b0;
      r_sel     <= 1'b0;
      r_ls      <= 1'b0;
      r_vm_reg  <= '0;
      r_a_reg   <= '0;
      r_a_off   <= '0;
      r_retired <= '0;
    end else begin
      r_state <= w_state_next;
      r_start <= w_pop;
      if (w_pop) begin
        r_sel    <= w_cmd_head.sel_v_m;
        r_ls     <= w_cmd_head.load_or_store;
        r_vm_reg <= w_cmd_head.sel_v_m ? (w_cmd_head.v_m_reg & M_MASK)
                                       : w_cmd_head.v_m_reg;
        r_a_reg  <= w_cmd_head.a_reg;
        r_a_off  <= w_cmd_head.a_offset;
      end
      if (w_retire) r_retired <= r_retired + 16'd1;
    end
  end

`ifdef MA_CMD_QUEUE_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wait_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      r_wait_cnt <= (r_state == ST_WAIT) ? r_wait_cnt + TW'(1) : '0;
      if (w_timeout) r_timeout <= 1'b1;
    end
  end

  assign timeout_o = r_timeout;
`endif

  assign ma_start_o           = r_start;
  assign ma_select_v_m_o      = r_sel;
  assign ma_v_load_or_store_o = r_ls;
  assign ma_v_m_reg_o         = r_vm_reg;
  assign ma_a_reg_o           = r_a_reg;
  assign ma_a_offset_o        = r_a_off;
  assign busy_o               = (r_state != ST_IDLE);
  assign retired_o            = r_retired;
  assign dbg_state_o          = r_state;

endmodule
